exu_alu_seq: RTL

//  Registered, parametrised execution ALU for the EXU. Accepts one operation per valid/ready

---
 rtl/exu_alu_seq_if.sv | 42 ++++
 rtl/exu_alu_seq.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exu_alu_seq_if.sv
// -----------------------------------------------------------------------------
// exu_alu_seq_if
//   Request/result bundle between dispatch, the EXU ALU and the writeback
//   arbiter.
//   master : dispatch / writeback side (drives the request, consumes results)
//   slave  : ALU side (accepts requests, presents the registered result)
//   Request : i_valid, i_ready, i_op, i_op1, i_op2, i_rdidx, i_rdwen, i_pc
//   Result  : o_valid, o_ready, o_wdat, o_rdidx, o_rdwen, o_pc, o_illegal,
//             o_longpipe
// -----------------------------------------------------------------------------
interface exu_alu_seq_if #(
  parameter int XLEN    = 32,
  parameter int RFIDX_W = 5,
  parameter int PC_W    = 32
);
  logic               i_valid;
  logic               i_ready;
  logic [4:0]         i_op;
  logic [XLEN-1:0]    i_op1;
  logic [XLEN-1:0]    i_op2;
  logic [RFIDX_W-1:0] i_rdidx;
  logic               i_rdwen;
  logic [PC_W-1:0]    i_pc;
  logic               o_valid;
  logic               o_ready;
  logic [XLEN-1:0]    o_wdat;
  logic [RFIDX_W-1:0] o_rdidx;
  logic               o_rdwen;
  logic [PC_W-1:0]    o_pc;
  logic               o_illegal;
  logic               o_longpipe;

  modport master (
    output i_valid, i_op, i_op1, i_op2, i_rdidx, i_rdwen, i_pc, o_ready,
    input  i_ready, o_valid, o_wdat, o_rdidx, o_rdwen, o_pc, o_illegal, o_longpipe
  );

  modport slave (
    input  i_valid, i_op, i_op1, i_op2, i_rdidx, i_rdwen, i_pc, o_ready,
    output i_ready, o_valid, o_wdat, o_rdidx, o_rdwen, o_pc, o_illegal, o_longpipe
  );
endinterface

// File: rtl/exu_alu_seq.sv
// -----------------------------------------------------------------------------
// exu_alu_seq
//   Registered execution ALU. One op per valid/ready handshake; the result,
//   together with its writeback tags, is held in a single-entry output register
//   until consumed. Regular ops take one cycle. When EXU_ALU_MULDIV_EN is
//   defined, MUL/MULH/MULHU/DIV/DIVU/REM/REMU run on an iterative engine
//   (shift-add multiply, restoring divide on magnitudes) taking XLEN+1 cycles;
//   otherwise those opcodes are reported illegal in one cycle.
// Ports
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : synchronous kill of the in-flight op and the output entry
//   alu_if     : exu_alu_seq_if.slave (request and result handshakes, tags,
//                o_illegal, o_longpipe)
// -----------------------------------------------------------------------------
module exu_alu_seq #(
  parameter int XLEN    = 32,
  parameter int RFIDX_W = 5,
  parameter int PC_W    = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  exu_alu_seq_if.slave alu_if
);
  localparam int SH_W  = $clog2(XLEN);
  localparam int CNT_W = $clog2(XLEN + 1);

  localparam logic [4:0] OP_ADD   = 5'd0;
  localparam logic [4:0] OP_SUB   = 5'd1;
  localparam logic [4:0] OP_XOR   = 5'd2;
  localparam logic [4:0] OP_OR    = 5'd3;
  localparam logic [4:0] OP_AND   = 5'd4;
  localparam logic [4:0] OP_SLL   = 5'd5;
  localparam logic [4:0] OP_SRL   = 5'd6;
  localparam logic [4:0] OP_SRA   = 5'd7;
  localparam logic [4:0] OP_SLT   = 5'd8;
  localparam logic [4:0] OP_SLTU  = 5'd9;
  localparam logic [4:0] OP_LUI   = 5'd10;
  localparam logic [4:0] OP_MUL   = 5'd16;
  localparam logic [4:0] OP_MULH  = 5'd17;
  localparam logic [4:0] OP_MULHU = 5'd18;
  localparam logic [4:0] OP_DIV   = 5'd19;
  localparam logic [4:0] OP_DIVU  = 5'd20;
  localparam logic [4:0] OP_REM   = 5'd21;
  localparam logic [4:0] OP_REMU  = 5'd22;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_e;

  function automatic logic [XLEN-1:0] alu_regular(input logic [4:0] op,
                                                  input logic [XLEN-1:0] a,
                                                  input logic [XLEN-1:0] b);
    logic [SH_W-1:0] sh;
    sh = b[SH_W-1:0];
    case (op)
      OP_ADD:  alu_regular = a + b;
      OP_SUB:  alu_regular = a - b;
      OP_XOR:  alu_regular = a ^ b;
      OP_OR:   alu_regular = a | b;
      OP_AND:  alu_regular = a & b;
      OP_SLL:  alu_regular = a << sh;
      OP_SRL:  alu_regular = a >> sh;
      OP_SRA:  alu_regular = $unsigned($signed(a) >>> sh);
      OP_SLT:  alu_regular = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: alu_regular = {{(XLEN-1){1'b0}}, (a < b)};
      OP_LUI:  alu_regular = b;
      default: alu_regular = {XLEN{1'b0}};
    endcase
  endfunction

  function automatic logic is_muldiv(input logic [4:0] op);
    is_muldiv = (op >= OP_MUL) && (op <= OP_REMU);
  endfunction

  function automatic logic is_legal(input logic [4:0] op);
`ifdef EXU_ALU_MULDIV_EN
    is_legal = (op <= OP_LUI) || is_muldiv(op);
`else
    is_legal = (op <= OP_LUI);
`endif
  endfunction

  state_e             state_r;
  state_e             state_nxt_s;
  logic               out_free_s;
  logic               i_ready_s;
  logic               accept_s;
  logic               start_md_s;
  logic               done_s;
  logic               o_valid_r;
  logic               o_illegal_r;
  logic [XLEN-1:0]    o_wdat_r;
  logic [RFIDX_W-1:0] o_rdidx_r;
  logic               o_rdwen_r;
  logic [PC_W-1:0]    o_pc_r;
  logic [XLEN-1:0]    md_wdat_s;
  logic [RFIDX_W-1:0] md_rdidx_s;
  logic               md_rdwen_s;
  logic [PC_W-1:0]    md_pc_s;

  // The output slot is free when empty or being consumed this cycle.
  assign out_free_s = ~o_valid_r | alu_if.o_ready;
  assign i_ready_s  = (state_r == IDLE) & out_free_s & ~flush;
  assign accept_s   = alu_if.i_valid & i_ready_s;

`ifdef EXU_ALU_MULDIV_EN
  logic [4:0]        op_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [2*XLEN-1:0] acc_r;
  logic [2*XLEN-1:0] mcand_r;
  logic [XLEN-1:0]   mplier_r;
  logic [XLEN-1:0]   quo_r;
  logic [XLEN-1:0]   rem_r;
  logic [XLEN-1:0]   divisor_r;
  logic [XLEN-1:0]   dividend_r;
  logic              a_neg_r;
  logic              b_neg_r;
  logic [RFIDX_W-1:0] rdidx_r;
  logic              rdwen_r;
  logic [PC_W-1:0]   pc_r;
  logic              signed_s;
  logic [XLEN-1:0]   mag_a_s;
  logic [XLEN-1:0]   mag_b_s;
  logic [XLEN:0]     rem_shift_s;
  logic              div_ge_s;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_fix_s;
  logic [XLEN-1:0]   rem_fix_s;
  logic              div0_s;

  // MUL takes the low half, so only MULH/DIV/REM need sign handling.
  assign signed_s = (alu_if.i_op == OP_MULH) | (alu_if.i_op == OP_DIV) | (alu_if.i_op == OP_REM);
  assign mag_a_s  = (signed_s & alu_if.i_op1[XLEN-1]) ? ({XLEN{1'b0}} - alu_if.i_op1) : alu_if.i_op1;
  assign mag_b_s  = (signed_s & alu_if.i_op2[XLEN-1]) ? ({XLEN{1'b0}} - alu_if.i_op2) : alu_if.i_op2;

  assign start_md_s = accept_s & is_muldiv(alu_if.i_op);
  // Completion waits with the counter at zero until the output slot frees.
  assign done_s     = (state_r == CALC) & (cnt_r == {CNT_W{1'b0}}) & out_free_s & ~flush;

  // Restoring-divide step: bring in the next dividend bit, subtract if it fits.
  assign rem_shift_s = {rem_r, quo_r[XLEN-1]};
  assign div_ge_s    = (rem_shift_s >= {1'b0, divisor_r});

  // Iterative engine: operand latch on accept, then one step per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r       <= 5'd0;
      cnt_r      <= {CNT_W{1'b0}};
      acc_r      <= {(2*XLEN){1'b0}};
      mcand_r    <= {(2*XLEN){1'b0}};
      mplier_r   <= {XLEN{1'b0}};
      quo_r      <= {XLEN{1'b0}};
      rem_r      <= {XLEN{1'b0}};
      divisor_r  <= {XLEN{1'b0}};
      dividend_r <= {XLEN{1'b0}};
      a_neg_r    <= 1'b0;
      b_neg_r    <= 1'b0;
      rdidx_r    <= {RFIDX_W{1'b0}};
      rdwen_r    <= 1'b0;
      pc_r       <= {PC_W{1'b0}};
    end else if (start_md_s) begin
      op_r       <= alu_if.i_op;
      cnt_r      <= CNT_W'(XLEN);
      acc_r      <= {(2*XLEN){1'b0}};
      mcand_r    <= {{XLEN{1'b0}}, mag_a_s};
      mplier_r   <= mag_b_s;
      quo_r      <= mag_a_s;
      rem_r      <= {XLEN{1'b0}};
      divisor_r  <= mag_b_s;
      dividend_r <= alu_if.i_op1;
      a_neg_r    <= signed_s & alu_if.i_op1[XLEN-1];
      b_neg_r    <= signed_s & alu_if.i_op2[XLEN-1];
      rdidx_r    <= alu_if.i_rdidx;
      rdwen_r    <= alu_if.i_rdwen;
      pc_r       <= alu_if.i_pc;
    end else if ((state_r == CALC) && (cnt_r != {CNT_W{1'b0}}) && !flush) begin
      if (mplier_r[0]) begin
        acc_r <= acc_r + mcand_r;
      end
      mcand_r  <= mcand_r << 1;
      mplier_r <= mplier_r >> 1;
      if (div_ge_s) begin
        rem_r <= XLEN'(rem_shift_s - {1'b0, divisor_r});
        quo_r <= {quo_r[XLEN-2:0], 1'b1};
      end else begin
        rem_r <= rem_shift_s[XLEN-1:0];
        quo_r <= {quo_r[XLEN-2:0], 1'b0};
      end
      cnt_r <= cnt_r - CNT_W'(1);
    end
  end

  // Final sign fix-up and divide-by-zero selection for the engine result.
  always_comb begin
    prod_s    = (a_neg_r ^ b_neg_r) ? ({(2*XLEN){1'b0}} - acc_r) : acc_r;
    quo_fix_s = (a_neg_r ^ b_neg_r) ? ({XLEN{1'b0}} - quo_r) : quo_r;
    rem_fix_s = a_neg_r ? ({XLEN{1'b0}} - rem_r) : rem_r;
    div0_s    = (divisor_r == {XLEN{1'b0}});
    md_wdat_s = {XLEN{1'b0}};
    case (op_r)
      OP_MUL:           md_wdat_s = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHU: md_wdat_s = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:  md_wdat_s = div0_s ? {XLEN{1'b1}} : quo_fix_s;
      OP_REM, OP_REMU:  md_wdat_s = div0_s ? dividend_r : rem_fix_s;
      default:          md_wdat_s = {XLEN{1'b0}};
    endcase
  end

  assign md_rdidx_s        = rdidx_r;
  assign md_rdwen_s        = rdwen_r;
  assign md_pc_s           = pc_r;
  assign alu_if.o_longpipe = (state_r == CALC);
`else
  assign start_md_s        = 1'b0;
  assign done_s            = 1'b0;
  assign md_wdat_s         = {XLEN{1'b0}};
  assign md_rdidx_s        = {RFIDX_W{1'b0}};
  assign md_rdwen_s        = 1'b0;
  assign md_pc_s           = {PC_W{1'b0}};
  assign alu_if.o_longpipe = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state; flush overrides both start and completion.
  always_comb begin
    state_nxt_s = state_r;
    if (flush) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_md_s) begin
            state_nxt_s = CALC;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        CALC: begin
          if (done_s) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = CALC;
          end
        end
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // Output register: loads 1-cycle results or engine completions, holds until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid_r   <= 1'b0;
      o_illegal_r <= 1'b0;
      o_wdat_r    <= {XLEN{1'b0}};
      o_rdidx_r   <= {RFIDX_W{1'b0}};
      o_rdwen_r   <= 1'b0;
      o_pc_r      <= {PC_W{1'b0}};
    end else if (flush) begin
      o_valid_r   <= 1'b0;
      o_illegal_r <= 1'b0;
    end else if (accept_s && !start_md_s) begin
      o_valid_r   <= 1'b1;
      o_illegal_r <= ~is_legal(alu_if.i_op);
      o_wdat_r    <= is_legal(alu_if.i_op) ? alu_regular(alu_if.i_op, alu_if.i_op1, alu_if.i_op2)
                                           : {XLEN{1'b0}};
      o_rdidx_r   <= alu_if.i_rdidx;
      o_rdwen_r   <= alu_if.i_rdwen;
      o_pc_r      <= alu_if.i_pc;
    end else if (done_s) begin
      o_valid_r   <= 1'b1;
      o_illegal_r <= 1'b0;
      o_wdat_r    <= md_wdat_s;
      o_rdidx_r   <= md_rdidx_s;
      o_rdwen_r   <= md_rdwen_s;
      o_pc_r      <= md_pc_s;
    end else if (alu_if.o_ready) begin
      o_valid_r   <= 1'b0;
      o_illegal_r <= 1'b0;
    end
  end

  assign alu_if.i_ready   = i_ready_s;
  assign alu_if.o_valid   = o_valid_r;
  assign alu_if.o_illegal = o_illegal_r;
  assign alu_if.o_wdat    = o_wdat_r;
  assign alu_if.o_rdidx   = o_rdidx_r;
  assign alu_if.o_rdwen   = o_rdwen_r;
  assign alu_if.o_pc      = o_pc_r;
endmodule
